// File: rtl/addsub_bist.sv
// Exhaustive sweep generator and response checker for an N-bit adder/subtractor.
// Drives {ci,a,b} = v for every v, predicts {co,sum} and scores the DUT response LAT clocks later.
module addsub_bist #(
  parameter int N   = 5,
  parameter int LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N-1:0]     a_o,
  output logic [N-1:0]     b_o,
  output logic             ci_o,
  input  logic [N-1:0]     sum_i,
  input  logic             co_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [2*N+1:0]   vec_cnt,
  output logic [2*N+1:0]   err_cnt,
  output logic [2*N:0]     first_fail
);

  // state | meaning
  // IDLE  | waiting for start after reset
  // RUN   | registering one vector per clock
  // DRAIN | last vector held while in-flight responses are checked
  // DONE  | results held until next start
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int          VW    = 2*N + 1;
  localparam logic [VW-1:0] VLAST = '1;

  logic [1:0]    state_q, state_d;
  logic [VW-1:0] vidx_q, vidx_d;
  logic [VW-1:0] vec_q;
  logic [2:0]    drain_q, drain_d;
  logic          load, clr;

  logic [LAT:0][N:0]    pexp_q;
  logic [LAT:0][VW-1:0] pidx_q;
  logic [LAT:0]         pval_q;

  logic [2*N+1:0] vec_cnt_q, err_cnt_q;
  logic [VW-1:0]  first_fail_q;

  logic [N-1:0] a_n, b_n;
  logic         ci_n;
  logic [N:0]   exp_n;
  logic         cmp_en, mismatch;

  always_comb begin
    state_d = state_q;
    vidx_d  = vidx_q;
    drain_d = drain_q;
    load    = 1'b0;
    clr     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          vidx_d  = '0;
          load    = 1'b1;
          clr     = 1'b1;
        end
      end
      RUN: begin
        vidx_d = vidx_q + 1'b1;
        load   = 1'b1;
        if (vidx_d == VLAST) begin
          state_d = DRAIN;
          drain_d = 3'(LAT + 1);
        end
      end
      DRAIN: begin
        // one extra clock beyond LAT so the last compare lands before DONE
        if (drain_q == 3'd0) state_d = DONE;
        else                 drain_d = drain_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ci_n  = vidx_d[2*N];
  assign a_n   = vidx_d[2*N-1:N];
  assign b_n   = vidx_d[N-1:0];
  assign exp_n = {1'b0, a_n} + {1'b0, b_n ^ {N{ci_n}}} + {{N{1'b0}}, ci_n};

  assign cmp_en   = pval_q[LAT] && !clr;
  assign mismatch = {co_i, sum_i} != pexp_q[LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      vidx_q       <= '0;
      vec_q        <= '0;
      drain_q      <= '0;
      pexp_q       <= '0;
      pidx_q       <= '0;
      pval_q       <= '0;
      vec_cnt_q    <= '0;
      err_cnt_q    <= '0;
      first_fail_q <= '0;
    end else begin
      state_q <= state_d;
      vidx_q  <= vidx_d;
      drain_q <= drain_d;
      if (load) vec_q <= vidx_d;

      for (int i = 1; i <= LAT; i++) begin
        pexp_q[i] <= pexp_q[i-1];
        pidx_q[i] <= pidx_q[i-1];
        pval_q[i] <= pval_q[i-1] && !clr;
      end
      pexp_q[0] <= exp_n;
      pidx_q[0] <= vidx_d;
      pval_q[0] <= load;

      if (clr) begin
        vec_cnt_q    <= '0;
        err_cnt_q    <= '0;
        first_fail_q <= '0;
      end else if (cmp_en) begin
        vec_cnt_q <= vec_cnt_q + 1'b1;
        if (mismatch) begin
          err_cnt_q <= err_cnt_q + 1'b1;
          if (err_cnt_q == '0) first_fail_q <= pidx_q[LAT];
        end
      end
    end
  end

  assign ci_o       = vec_q[2*N];
  assign a_o        = vec_q[2*N-1:N];
  assign b_o        = vec_q[N-1:0];
  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign done       = (state_q == DONE);
  assign pass       = done && (err_cnt_q == '0);
  assign vec_cnt    = vec_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign first_fail = first_fail_q;

endmodule
